// File: rtl/program_loader.sv
// Boot loader: receives a framed program over a byte valid/ready handshake, writes
// big-endian 32-bit words to instruction memory and releases the CPU on a good checksum.
module program_loader #(
   parameter int                    ADDR_WIDTH    = 32,
   parameter int                    MAX_WORDS     = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS  = {ADDR_WIDTH{1'b0}},
   parameter logic [7:0]            SYNC_BYTE     = 8'hA5,
   parameter logic                  HOLD_AT_RESET = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            byteIn,
   input  logic                  byteValid,
   output logic                  byteReady,
   output logic [ADDR_WIDTH-1:0] memAddress,
   output logic [31:0]           memWriteData,
   output logic                  memWrite,
   output logic                  cpuHold,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           wordCount
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_CHECK  = 3'd5,
      S_DONE   = 3'd6,
      S_ERROR  = 3'd7
   } state_t;

   localparam logic [16:0] MAX_WORDS_C = 17'(MAX_WORDS);

   // Running XOR checksum over data bytes.
   function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   state_t                  state_r, state_n;
   logic [15:0]             len_r, len_n;
   logic [23:0]             word_r, word_n;
   logic [1:0]              byte_cnt_r, byte_cnt_n;
   logic [7:0]              chk_r, chk_n;
   logic [15:0]             word_count_r, word_count_n;
   logic [ADDR_WIDTH-1:0]   addr_r, addr_n;
   logic [31:0]             data_r, data_n;
   logic                    mem_write_r, mem_write_n;
   logic                    hold_r, hold_n;
   logic                    done_r, done_n;
   logic                    error_r, error_n;
   logic                    ready_r, ready_n;
   logic                    transfer_s;
   logic [15:0]             len_v_s;
   logic [15:0]             wc_inc_s;

   assign transfer_s = byteValid & ready_r;

   // State register and registered datapath/outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= S_IDLE;
         len_r        <= 16'd0;
         word_r       <= 24'd0;
         byte_cnt_r   <= 2'd0;
         chk_r        <= 8'd0;
         word_count_r <= 16'd0;
         addr_r       <= BASE_ADDRESS;
         data_r       <= 32'd0;
         mem_write_r  <= 1'b0;
         hold_r       <= HOLD_AT_RESET;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
         ready_r      <= 1'b1;
      end else begin
         state_r      <= state_n;
         len_r        <= len_n;
         word_r       <= word_n;
         byte_cnt_r   <= byte_cnt_n;
         chk_r        <= chk_n;
         word_count_r <= word_count_n;
         addr_r       <= addr_n;
         data_r       <= data_n;
         mem_write_r  <= mem_write_n;
         hold_r       <= hold_n;
         done_r       <= done_n;
         error_r      <= error_n;
         ready_r      <= ready_n;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n      = state_r;
      len_n        = len_r;
      word_n       = word_r;
      byte_cnt_n   = byte_cnt_r;
      chk_n        = chk_r;
      word_count_n = word_count_r;
      addr_n       = addr_r;
      data_n       = data_r;
      mem_write_n  = 1'b0;
      hold_n       = hold_r;
      done_n       = done_r;
      error_n      = error_r;
      len_v_s      = {len_r[15:8], byteIn};
      wc_inc_s     = word_count_r + 16'd1;

      case (state_r)
         S_IDLE, S_DONE, S_ERROR: begin
            if (transfer_s && (byteIn == SYNC_BYTE)) begin
               state_n      = S_LEN_HI;
               done_n       = 1'b0;
               error_n      = 1'b0;
               word_count_n = 16'd0;
               chk_n        = 8'd0;
               byte_cnt_n   = 2'd0;
               hold_n       = 1'b1;
            end else begin
               state_n = state_r;
            end
         end
         S_LEN_HI: begin
            if (transfer_s) begin
               len_n   = {byteIn, 8'd0};
               state_n = S_LEN_LO;
            end else begin
               state_n = state_r;
            end
         end
         S_LEN_LO: begin
            if (transfer_s) begin
               len_n = len_v_s;
               if ({1'b0, len_v_s} > MAX_WORDS_C) begin
                  state_n = S_ERROR;
                  error_n = 1'b1;
               end else if (len_v_s == 16'd0) begin
                  state_n = S_CHECK;
               end else begin
                  state_n = S_DATA;
               end
            end else begin
               state_n = state_r;
            end
         end
         S_DATA: begin
            if (transfer_s) begin
               word_n     = {word_r[15:0], byteIn};
               chk_n      = chk_next(chk_r, byteIn);
               byte_cnt_n = byte_cnt_r + 2'd1;
               if (byte_cnt_r == 2'd3) begin
                  // Word address uses the count before the post-write increment.
                  state_n     = S_WRITE;
                  mem_write_n = 1'b1;
                  data_n      = {word_r, byteIn};
                  addr_n      = BASE_ADDRESS + ADDR_WIDTH'({word_count_r, 2'b00});
               end else begin
                  state_n = S_DATA;
               end
            end else begin
               state_n = state_r;
            end
         end
         S_WRITE: begin
            word_count_n = wc_inc_s;
            if (wc_inc_s < len_r) begin
               state_n = S_DATA;
            end else begin
               state_n = S_CHECK;
            end
         end
         S_CHECK: begin
            if (transfer_s) begin
               if (byteIn == chk_r) begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
                  hold_n  = 1'b0;
               end else begin
                  state_n = S_ERROR;
                  error_n = 1'b1;
               end
            end else begin
               state_n = state_r;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      ready_n = (state_n != S_WRITE);
   end

   assign byteReady    = ready_r;
   assign memAddress   = addr_r;
   assign memWriteData = data_r;
   assign memWrite     = mem_write_r;
   assign cpuHold      = hold_r;
   assign done         = done_r;
   assign error        = error_r;
   assign wordCount    = word_count_r;

endmodule
